// File: rtl/alu_op_encoder_5.sv
// One-hot ALU request encoder feeding a small FIFO of {opcode, shift amount} entries.
// Non-one-hot requests are dropped, flagged with a one-cycle pulse and counted (saturating).
module alu_op_encoder_5 #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [5:0]               req_op,
  input  logic [4:0]               req_shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               ctrl,
  output logic [4:0]               shamt,
  output logic                     err_illegal,
  output logic [7:0]               illegal_count,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  function automatic logic is_onehot(input logic [5:0] op);
    return (op != 6'd0) && ((op & (op - 6'd1)) == 6'd0);
  endfunction

  function automatic logic [4:0] encode_op(input logic [5:0] op);
    logic [4:0] enc;
    case (op)
      6'b000001: enc = 5'b00000;
      6'b000010: enc = 5'b00001;
      6'b000100: enc = 5'b00010;
      6'b001000: enc = 5'b00011;
      6'b010000: enc = 5'b00100;
      6'b100000: enc = 5'b00101;
      default:   enc = 5'b00000;
    endcase
    return enc;
  endfunction

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    illegal_count_q, illegal_count_d;
  logic          err_q, err_d;
  logic [4:0]    ctrl_mem_q  [DEPTH];
  logic [4:0]    shamt_mem_q [DEPTH];

  logic legal_s, push_s, reject_s, pop_s;
  logic [4:0] enc_ctrl_s, enc_shamt_s;

  assign req_ready = (count_q != CNT_FULL);
  assign out_valid = (count_q != {CW{1'b0}});

  // Request classification and next-state for pointers, occupancy and error tracking.
  always_comb begin
    legal_s         = is_onehot(req_op);
    push_s          = 1'b0;
    reject_s        = 1'b0;
    pop_s           = out_valid && out_ready;
    enc_ctrl_s      = encode_op(req_op);
    enc_shamt_s     = 5'd0;
    head_d          = head_q;
    tail_d          = tail_q;
    count_d         = count_q;
    illegal_count_d = illegal_count_q;
    err_d           = 1'b0;

    if (req_valid && req_ready) begin
      push_s   = legal_s;
      reject_s = !legal_s;
    end else begin
      push_s   = 1'b0;
      reject_s = 1'b0;
    end

    // Only shifts carry a shift amount; everything else stores zero.
    if (req_op[4] || req_op[5]) begin
      enc_shamt_s = req_shamt;
    end else begin
      enc_shamt_s = 5'd0;
    end

    if (push_s) begin
      tail_d = tail_q + PTR_ONE;
    end else begin
      tail_d = tail_q;
    end

    if (pop_s) begin
      head_d = head_q + PTR_ONE;
    end else begin
      head_d = head_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (reject_s && (illegal_count_q != 8'hFF)) begin
      illegal_count_d = illegal_count_q + 8'd1;
    end else begin
      illegal_count_d = illegal_count_q;
    end

    err_d = reject_s;
  end

  // Control state: cleared asynchronously so a reset drops all queued entries at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q          <= {AW{1'b0}};
      tail_q          <= {AW{1'b0}};
      count_q         <= {CW{1'b0}};
      illegal_count_q <= 8'd0;
      err_q           <= 1'b0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      illegal_count_q <= illegal_count_d;
      err_q           <= err_d;
    end
  end

  // Entry storage; validity is tracked by count, so contents need no reset.
  always_ff @(posedge clock) begin
    if (push_s) begin
      ctrl_mem_q[tail_q]  <= enc_ctrl_s;
      shamt_mem_q[tail_q] <= enc_shamt_s;
    end
  end

  assign ctrl          = out_valid ? ctrl_mem_q[head_q]  : 5'd0;
  assign shamt         = out_valid ? shamt_mem_q[head_q] : 5'd0;
  assign err_illegal   = err_q;
  assign illegal_count = illegal_count_q;
  assign count         = count_q;

endmodule

// File: tb/tb_alu_op_encoder_5.sv
// Scoreboard bench for alu_op_encoder_5: the driver queues expected entries,
// a negedge monitor compares every popped head entry against the queue.
module tb_alu_op_encoder_5;

  logic       clock;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_op;
  logic [4:0] req_shamt;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] ctrl;
  logic [4:0] shamt;
  logic       err_illegal;
  logic [7:0] illegal_count;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  alu_op_encoder_5 #(.DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_shamt(req_shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl(ctrl), .shamt(shamt),
    .err_illegal(err_illegal), .illegal_count(illegal_count),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle the DUT hands over an entry, compare it with the oldest expected one.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 1, 0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("pop_ctrl", int'(ctrl), int'(e[9:5]));
        chk("pop_shamt", int'(shamt), int'(e[4:0]));
      end
    end
  end

  // Present one request until accepted (bounded), queueing its expected entry if legal.
  task automatic send(input logic [5:0] op, input logic [4:0] sh,
                      input logic legal, input logic [4:0] ec, input logic [4:0] es);
    int waited;
    req_valid = 1'b1;
    req_op    = op;
    req_shamt = sh;
    waited    = 0;
    @(negedge clock);
    while (!req_ready && waited < 20) begin
      waited++;
      @(negedge clock);
    end
    if (!req_ready) chk("send_timeout", 0, 1);
    if (legal) exp_q.push_back({ec, es});
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  logic [5:0] s_op [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
  logic [4:0] s_ec [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
  logic [4:0] s_es [6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd17, 5'd17};

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_op = 6'd0; req_shamt = 5'd0; out_ready = 1'b0;
    #12;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_ctrl", int'(ctrl), 0);
    chk("rst_shamt", int'(shamt), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_err", int'(err_illegal), 0);
    chk("rst_illegal_count", int'(illegal_count), 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Single ops through an empty FIFO; req_shamt=17 always, only shifts keep it.
    for (int i = 0; i < 6; i++) begin
      send(s_op[i], 5'd17, 1'b1, s_ec[i], s_es[i]);
      chk("single_valid", int'(out_valid), 1);
      chk("single_ctrl", int'(ctrl), int'(s_ec[i]));
      chk("single_shamt", int'(shamt), int'(s_es[i]));
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      chk("single_empty_valid", int'(out_valid), 0);
      chk("single_empty_ctrl", int'(ctrl), 0);
    end

    // Fill to four entries, then check a full FIFO ignores both illegal and legal requests.
    send(6'b000010, 5'd9,  1'b1, 5'd1, 5'd0);
    send(6'b001000, 5'd7,  1'b1, 5'd3, 5'd0);
    send(6'b100000, 5'd31, 1'b1, 5'd5, 5'd31);
    send(6'b000100, 5'd3,  1'b1, 5'd2, 5'd0);
    chk("full_count", int'(count), 4);
    chk("full_ready", int'(req_ready), 0);
    req_valid = 1'b1; req_op = 6'b000011; req_shamt = 5'd0;
    repeat (2) @(posedge clock); #1;
    chk("full_illegal_err", int'(err_illegal), 0);
    chk("full_illegal_cnt", int'(illegal_count), 0);
    req_op = 6'b010000; req_shamt = 5'd5;
    repeat (2) @(posedge clock); #1;
    chk("full_hold_count", int'(count), 4);
    chk("full_hold_ready", int'(req_ready), 0);
    exp_q.push_back({5'd4, 5'd5});
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("after_pop_ready", int'(req_ready), 1);
    chk("after_pop_count", int'(count), 3);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("fifth_taken_count", int'(count), 4);
    out_ready = 1'b1;
    repeat (6) @(posedge clock); #1;
    out_ready = 1'b0;
    chk("drain_count", int'(count), 0);

    // Streaming at occupancy 2: one push and one pop every cycle, pointers wrap several times.
    send(6'b000001, 5'd0, 1'b1, 5'd0, 5'd0);
    send(6'b010000, 5'd1, 1'b1, 5'd4, 5'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int k;
      k = i % 6;
      send(6'b000001 << k, 5'(i + 3), 1'b1, 5'(k), (k >= 4) ? 5'(i + 3) : 5'd0);
      chk("stream_count", int'(count), 2);
    end
    repeat (3) @(posedge clock); #1;
    out_ready = 1'b0;
    chk("stream_drained", int'(count), 0);

    // Illegal requests back to back: continuous pulse, one increment each, nothing enqueued.
    req_valid = 1'b1; req_op = 6'b000000;
    @(posedge clock); #1;
    chk("ill1_err", int'(err_illegal), 1);
    chk("ill1_cnt", int'(illegal_count), 1);
    req_op = 6'b000011;
    @(posedge clock); #1;
    chk("ill2_err", int'(err_illegal), 1);
    chk("ill2_cnt", int'(illegal_count), 2);
    req_op = 6'b100001;
    @(posedge clock); #1;
    chk("ill3_err", int'(err_illegal), 1);
    chk("ill3_cnt", int'(illegal_count), 3);
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("ill_err_drop", int'(err_illegal), 0);
    chk("ill_no_enqueue", int'(count), 0);
    req_valid = 1'b1; req_op = 6'b000000;
    repeat (300) @(posedge clock); #1;
    req_valid = 1'b0;
    chk("ill_saturate", int'(illegal_count), 255);

    // Asynchronous reset with three entries queued.
    send(6'b000001, 5'd0, 1'b1, 5'd0, 5'd0);
    send(6'b000010, 5'd0, 1'b1, 5'd1, 5'd0);
    send(6'b001000, 5'd0, 1'b1, 5'd3, 5'd0);
    chk("pre_reset_count", int'(count), 3);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_ctrl", int'(ctrl), 0);
    chk("arst_count", int'(count), 0);
    chk("arst_ready", int'(req_ready), 1);
    chk("arst_illegal_count", int'(illegal_count), 0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    send(6'b100000, 5'd22, 1'b1, 5'd5, 5'd22);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_ctrl", int'(ctrl), 5);
    chk("post_rst_shamt", int'(shamt), 22);
    out_ready = 1'b1;
    repeat (2) @(posedge clock); #1;
    out_ready = 1'b0;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_encoder_5.md
# alu_op_encoder_5

Issue-side counterpart of the ALU opcode decoder: accepts one-hot operation requests plus a shift amount from the control path, encodes each into the 5-bit ALU opcode, and buffers them in a small FIFO. It sits between the instruction control logic and the ALU's `ctrl` opcode and shift-amount inputs. Non-one-hot requests are rejected and counted.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_op`  in  6  one-hot operation: bit0 add, bit1 sub, bit2 and, bit3 or, bit4 sll, bit5 sra.
- `req_shamt`  in  5  shift amount; meaningful only for sll and sra.
- `out_valid`  out  1  head entry is present.
- `out_ready`  in  1  consumer takes the head entry.
- `ctrl`  out  5  encoded ALU opcode of the head entry.
- `shamt`  out  5  shift amount of the head entry.
- `err_illegal`  out  1  one-cycle pulse for a rejected request.
- `illegal_count`  out  8  saturating count of rejected requests.
- `count`  out  log2(DEPTH)+1  current occupancy.

## Operation
- Encoding: add 00000, sub 00001, and 00010, or 00011, sll 00100, sra 00101.
- Legal request: `req_op` has exactly one bit set.
- Stored shift amount: `req_shamt` for sll and sra. It is forced to 0 for all other ops.
- Accept condition: `req_valid && req_ready && legal`. The accepted entry is written at the tail, and the tail pointer wraps modulo DEPTH.
- Reject condition: `req_valid && req_ready && !legal`.
  - Nothing is enqueued.
  - `err_illegal` pulses high the next cycle.
  - `illegal_count` increments and saturates at 255.
- `req_ready` = `count != DEPTH`, taken from registered state. It does not depend on `out_ready`, so a push is refused when the FIFO is full even in a cycle that pops.
- Pop condition: `out_valid && out_ready`. The head pointer advances and wraps modulo DEPTH.
- Simultaneous accept and pop with `0 < count < DEPTH`: `count` is unchanged and both pointers advance.
- `out_valid` = `count != 0`.
- While `out_valid` is 0, `ctrl` and `shamt` are driven as 00000, never stale data.
- Once `out_valid` is high, the head entry's values stay stable until the entry is popped.
- `req_valid` with `req_ready` low is ignored: no error and no count change.

## Timing
- Reset while `reset_n` is low:
  - Pointers and `count` are 0, and `illegal_count` is 0.
  - `req_ready`=1, `out_valid`=0, `ctrl`=0, `shamt`=0, `err_illegal`=0.
  - Storage contents need not be reset.
- Reset asserted mid-operation discards all queued entries immediately, asynchronously.
- Latency: a request accepted at edge N is visible on `ctrl`/`shamt` with `out_valid`=1 after edge N, when the FIFO was empty. There is no combinational bypass from request to output.
- Throughput: one accept and one pop per cycle.
- A pop at edge N frees space, and `req_ready` rises after edge N.
- `err_illegal` is registered, high for exactly the one cycle following the rejecting edge. Back-to-back illegal requests give a continuous high and one increment per request.

## Test plan
- Single ops, empty FIFO:
  - Stimulus: one legal request per op, each followed by a pop.
  - Response: `ctrl` shows 00000, 00001, 00010, 00011, 00100, 00101 one cycle after acceptance.
  - Response: `shamt`=0 for add, sub, and, or.
  - Response: `shamt` equals `req_shamt` (e.g. 5'd17) for sll and sra.
- Fill and order:
  - Stimulus: 4 accepts with `out_ready`=0, then a 5th request held valid.
  - Response: `req_ready`=0 and `count`=4, and the 5th request is not taken.
  - Response: popping yields the entries in submission order, and `req_ready` returns the cycle after the first pop.
- Simultaneous push and pop:
  - Stimulus: continuous `req_valid` and `out_ready` for 10 cycles at `count`=2.
  - Response: `count` stays 2, the 10 entries emerge in order, and the pointers wrap correctly.
- Illegal requests:
  - Stimulus: `req_op`=000000, then 000011, then 100001.
  - Response: no enqueue, `err_illegal` high for 3 consecutive cycles, `illegal_count`=3.
  - Stimulus: 300 illegal requests.
  - Response: `illegal_count` saturates at 255.
- Reset mid-stream:
  - Stimulus: assert `reset_n` low asynchronously with 3 entries queued.
  - Response: immediately `out_valid`=0, `ctrl`=0, `count`=0, `req_ready`=1.
  - Response: after release, the first new request appears with the correct encoding.
